// File: rtl/preg_freelist_if.sv
// Rename/retire handshake bundle between the rename lanes, retire stage and the free list.
interface preg_freelist_if;
  logic       alloc_req0;
  logic       alloc_req1;
  logic       alloc_gnt0;
  logic       alloc_gnt1;
  logic [5:0] alloc_preg0;
  logic [5:0] alloc_preg1;
  logic       rel_valid;
  logic [5:0] rel_preg;
  logic       ready;
  logic [6:0] free_count;
  logic       err;

  modport master (
    output alloc_req0, alloc_req1, rel_valid, rel_preg,
    input  alloc_gnt0, alloc_gnt1, alloc_preg0, alloc_preg1, ready, free_count, err
  );

  modport slave (
    input  alloc_req0, alloc_req1, rel_valid, rel_preg,
    output alloc_gnt0, alloc_gnt1, alloc_preg0, alloc_preg1, ready, free_count, err
  );
endinterface

// File: rtl/preg_freelist.sv
// Physical-register free list: circular FIFO of tags, two allocation lanes, one release port.
// Optional FREELIST_DUP_CHECK_EN adds an in-list vector that rejects duplicate/unallocated releases.
module preg_freelist #(
  parameter int unsigned NUM_PREG = 64,
  parameter int unsigned NUM_AREG = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  preg_freelist_if.slave fl
);
  localparam int unsigned TAG_W    = 6;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned PTR_W    = $clog2(NUM_PREG);
  localparam int unsigned NUM_INIT = NUM_PREG - NUM_AREG;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TAG_W-1:0] entry [NUM_PREG];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             err_q;

  logic             in_init;
  logic             in_ready;
  logic             gnt0;
  logic             gnt1;
  logic             init_last;
  logic             dup_ok;
  logic             rel_acc;
  logic             rel_bad;
  logic             wr_en;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] head_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [TAG_W-1:0] wr_data;
  logic [TAG_W-1:0] preg0;
  logic [TAG_W-1:0] preg1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_PREG - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // During INIT the tail pointer doubles as the init index
  assign head_p1   = ptr_inc(head);
  assign init_last = (tail == PTR_W'(NUM_INIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // INIT leaves on the edge that writes the last tag; READY is left only by reset
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_last) state_nxt = ST_READY;
  end

  // Grants: lane 0 has priority, lane 1 takes the entry after lane 0's
  always_comb begin
    in_init  = 1'b0;
    in_ready = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    case (state)
      ST_INIT:  in_init = 1'b1;
      ST_READY: begin
        in_ready = 1'b1;
        gnt0     = fl.alloc_req0 && (count >= CNT_W'(1));
        gnt1     = fl.alloc_req1 && (gnt0 ? (count >= CNT_W'(2)) : (count >= CNT_W'(1)));
      end
      default: ;
    endcase
  end

  assign preg0 = entry[head];
  assign preg1 = gnt0 ? entry[head_p1] : entry[head];

`ifdef FREELIST_DUP_CHECK_EN
  logic [NUM_PREG-1:0] in_list;
  logic [NUM_PREG-1:0] ever_gnt;

  // Identity-mapped tags are only returnable after they have been handed out once
  assign dup_ok = !in_list[fl.rel_preg] &&
                  ((fl.rel_preg >= TAG_W'(NUM_AREG)) || ever_gnt[fl.rel_preg]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_list  <= '0;
      ever_gnt <= '0;
    end else begin
      if (gnt0) begin
        in_list[preg0]  <= 1'b0;
        ever_gnt[preg0] <= 1'b1;
      end
      if (gnt1) begin
        in_list[preg1]  <= 1'b0;
        ever_gnt[preg1] <= 1'b1;
      end
      if (wr_en) in_list[wr_data] <= 1'b1;
    end
  end
`else
  assign dup_ok = 1'b1;
`endif

  assign rel_acc = fl.rel_valid && in_ready && (count != CNT_W'(NUM_PREG)) && dup_ok;
  assign rel_bad = fl.rel_valid && !rel_acc;
  assign wr_en   = in_init || rel_acc;
  assign wr_data = in_init ? TAG_W'(NUM_AREG + 32'(tail)) : fl.rel_preg;

  always_comb begin
    head_nxt = head;
    if (gnt0 && gnt1)      head_nxt = ptr_inc(head_p1);
    else if (gnt0 || gnt1) head_nxt = head_p1;
    count_nxt = count + CNT_W'(rel_acc) - CNT_W'(gnt0) - CNT_W'(gnt1);
    if (in_init) count_nxt = count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      head  <= head_nxt;
      count <= count_nxt;
      if (wr_en)   tail  <= ptr_inc(tail);
      if (rel_bad) err_q <= 1'b1;
    end
  end

  // Buffer contents carry no meaning until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) entry[tail] <= wr_data;
  end

  assign fl.alloc_gnt0  = gnt0;
  assign fl.alloc_gnt1  = gnt1;
  assign fl.alloc_preg0 = preg0;
  assign fl.alloc_preg1 = preg1;
  assign fl.ready       = in_ready;
  assign fl.free_count  = count;
  assign fl.err         = err_q;
endmodule

// File: tb/tb_preg_freelist.sv
// Directed + random bench for preg_freelist; a FIFO queue model predicts grant tags and counts.
module tb_preg_freelist;
  localparam int unsigned NUM_PREG = 64;
  localparam int unsigned NUM_AREG = 32;
`ifdef FREELIST_DUP_CHECK_EN
  localparam logic [5:0] REL_TAG = 6'd40;
`else
  localparam logic [5:0] REL_TAG = 6'd5;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  preg_freelist_if fl ();
  preg_freelist #(.NUM_PREG(NUM_PREG), .NUM_AREG(NUM_AREG)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fl   (fl)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [5:0] exp_q [$];
  logic [5:0] pool  [$];
  logic       m_err;
`ifdef FREELIST_DUP_CHECK_EN
  bit         seen [NUM_PREG];
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    fl.alloc_req0 = 1'b0;
    fl.alloc_req1 = 1'b0;
    fl.rel_valid  = 1'b0;
    fl.rel_preg   = 6'd0;
  endtask

  function automatic bit model_accept(input logic [5:0] t);
    bit ok = (exp_q.size() < NUM_PREG);
`ifdef FREELIST_DUP_CHECK_EN
    foreach (exp_q[i]) if (exp_q[i] == t) ok = 1'b0;
    if (t < 6'(NUM_AREG) && !seen[t]) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic void pool_remove(input logic [5:0] t);
    for (int i = 0; i < pool.size(); i++) begin
      if (pool[i] == t) begin
        pool.delete(i);
        return;
      end
    end
  endfunction

  task automatic record_grant(input logic [5:0] t);
    pool.push_back(t);
`ifdef FREELIST_DUP_CHECK_EN
    seen[t] = 1'b1;
`endif
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive_idle();
    fl.alloc_req0 = 1'b1;
    fl.alloc_req1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(fl.ready), 32'd0);
    chk("rst_gnt0",  32'(fl.alloc_gnt0), 32'd0);
    chk("rst_gnt1",  32'(fl.alloc_gnt1), 32'd0);
    chk("rst_count", 32'(fl.free_count), 32'd0);
    chk("rst_err",   32'(fl.err), 32'd0);
    exp_q.delete();
    pool.delete();
    m_err = 1'b0;
`ifdef FREELIST_DUP_CHECK_EN
    foreach (seen[i]) seen[i] = 1'b0;
`endif
    drive_idle();
  endtask

  // Runs n INIT cycles from reset release; a full run must end with ready high
  task automatic init_cycles(input int n, input int rel_at);
    for (int k = 0; k < n; k++) begin
      rst_n         = 1'b1;
      fl.alloc_req0 = 1'b1;
      fl.alloc_req1 = 1'b1;
      fl.rel_valid  = (k == rel_at);
      fl.rel_preg   = 6'd40;
      #2;
      chk("init_ready", 32'(fl.ready), 32'd0);
      chk("init_gnt0",  32'(fl.alloc_gnt0), 32'd0);
      chk("init_gnt1",  32'(fl.alloc_gnt1), 32'd0);
      chk("init_count", 32'(fl.free_count), 32'(k));
      if (k == rel_at) m_err = 1'b1;
      @(negedge clk);
      chk("init_err", 32'(fl.err), 32'(m_err));
    end
    drive_idle();
    if (n == int'(NUM_PREG - NUM_AREG)) begin
      chk("ready_rise", 32'(fl.ready), 32'd1);
      chk("ready_free", 32'(fl.free_count), 32'(NUM_PREG - NUM_AREG));
      for (int t = NUM_AREG; t < NUM_PREG; t++) exp_q.push_back(6'(t));
    end
  endtask

  // One READY cycle: predict grants from the model before the edge, counts after it
  task automatic cycle(input logic r0, input logic r1, input logic rv, input logic [5:0] rp);
    logic e0, e1, acc;
    logic [5:0] t;
    fl.alloc_req0 = r0;
    fl.alloc_req1 = r1;
    fl.rel_valid  = rv;
    fl.rel_preg   = rp;
    #2;
    e0  = r0 && (exp_q.size() >= 1);
    e1  = r1 && (e0 ? (exp_q.size() >= 2) : (exp_q.size() >= 1));
    acc = rv && model_accept(rp);
    chk("gnt0", 32'(fl.alloc_gnt0), 32'(e0));
    chk("gnt1", 32'(fl.alloc_gnt1), 32'(e1));
    if (e0) begin
      t = exp_q.pop_front();
      chk("preg0", 32'(fl.alloc_preg0), 32'(t));
      record_grant(t);
    end
    if (e1) begin
      t = exp_q.pop_front();
      chk("preg1", 32'(fl.alloc_preg1), 32'(t));
      record_grant(t);
    end
    if (acc) exp_q.push_back(rp);
    else if (rv) m_err = 1'b1;
    @(negedge clk);
    chk("free_count", 32'(fl.free_count), 32'(exp_q.size()));
    chk("err",        32'(fl.err), 32'(m_err));
    chk("ready",      32'(fl.ready), 32'd1);
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r0, r1, rv;
    logic [5:0] rp;
    int idx;
    drive_idle();
    rst_n = 1'b0;
    m_err = 1'b0;
    @(negedge clk);

    reset_dut();
    init_cycles(32, -1);

    cycle(1'b1, 1'b1, 1'b0, 6'd0);
    chk("dual_free", 32'(fl.free_count), 32'd30);

    while (exp_q.size() > 2) cycle(1'b1, 1'b1, 1'b0, 6'd0);
    cycle(1'b1, 1'b0, 1'b0, 6'd0);
    cycle(1'b1, 1'b1, 1'b0, 6'd0);
    chk("last_free", 32'(fl.free_count), 32'd0);

    // No bypass: a release into an empty list is grantable only next cycle
    pool_remove(REL_TAG);
    cycle(1'b1, 1'b0, 1'b1, REL_TAG);
    cycle(1'b1, 1'b0, 1'b0, 6'd0);

    for (int i = 0; i < 100; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      rv = (pool.size() > 0) && ($urandom_range(0, 9) < 7);
      rp = 6'd0;
      if (rv) begin
        idx = int'($urandom_range(0, pool.size() - 1));
        rp  = pool[idx];
        pool.delete(idx);
      end
      cycle(r0, r1, rv, rp);
    end

`ifndef FREELIST_DUP_CHECK_EN
    while (exp_q.size() < NUM_PREG) cycle(1'b0, 1'b0, 1'b1, 6'd0);
    cycle(1'b0, 1'b0, 1'b1, 6'd1);
    chk("overflow_free", 32'(fl.free_count), 32'(NUM_PREG));
`endif

    reset_dut();
    init_cycles(10, 3);
    reset_dut();
    init_cycles(32, -1);

`ifdef FREELIST_DUP_CHECK_EN
    cycle(1'b0, 1'b0, 1'b1, 6'd40);
    chk("dup_free", 32'(fl.free_count), 32'd32);
    cycle(1'b0, 1'b0, 1'b1, 6'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/preg_freelist.md
PREG_FREELIST -- requirements
Module: preg_freelist

Interface
REQ-001 SHALL have parameter NUM_PREG, default 64, number of physical registers; tag width 6 bits.
REQ-002 SHALL have parameter NUM_AREG, default 32, number of architectural registers, identity-mapped at reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have ports alloc_req0 / alloc_req1  input  1 each  rename lane 0 / lane 1 requests a free physical register.
REQ-006 SHALL have ports alloc_gnt0 / alloc_gnt1  output  1 each  combinational grant to lane 0 / lane 1.
REQ-007 SHALL have ports alloc_preg0 / alloc_preg1  output  6 each  granted tag, valid only while the matching grant is 1.
REQ-008 SHALL have port rel_valid  input  1  retire stage returns one tag this cycle.
REQ-009 SHALL have port rel_preg  input  6  tag being returned.
REQ-010 SHALL have port ready  output  1  initialisation complete; allocation is possible.
REQ-011 SHALL have port free_count  output  7  number of tags currently in the free list.
REQ-012 SHALL have port err  output  1  sticky flag for an illegal release; cleared only by reset.

Function
REQ-013 SHALL hold the free list in a circular buffer of NUM_PREG 6-bit entries, with head pointer, tail pointer and a 7-bit count.
REQ-014 SHALL implement the FSM INIT -> READY; INIT writes tag NUM_AREG+i into entry i for i = 0..NUM_PREG-NUM_AREG-1, one per cycle, and increments count each cycle.
REQ-015 SHALL move INIT -> READY on the cycle after the last tag (63) is written, giving ready=1 after 32 cycles at the default parameters; READY SHALL have no exit except reset.
REQ-016 SHALL hold ready=0 and both grants at 0 in INIT, and SHALL ignore rel_valid in INIT while setting err.
REQ-017 SHALL, in READY, assert alloc_gnt0 = alloc_req0 && count>=1, with alloc_preg0 = entry[head].
REQ-018 SHALL use fixed priority with lane 0 first: lane 1 takes entry[head] if lane 0 does not request, or entry[head+1] if lane 0 is granted; alloc_gnt1 SHALL require count>=2 when both lanes are granted and count>=1 otherwise.
REQ-019 SHALL advance head by the number of grants (0, 1 or 2) at the clock edge, with pointers wrapping modulo NUM_PREG.
REQ-020 SHALL write rel_preg at tail and advance tail by 1 at the edge when rel_valid=1 in READY.
REQ-021 SHALL provide no bypass: a tag released in cycle N is grantable no earlier than cycle N+1; release with count=0 and simultaneous requests gives no grant.
REQ-022 SHALL compute next count = count + rel_accepted - grants in the same cycle; simultaneous release and allocation is legal.
REQ-023 SHALL drop a release when count=NUM_PREG (overflow) and set err.
REQ-024 SHALL drive free_count directly from count (registered).

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, set state=INIT, head=0, tail=0, count=0, err=0 and the init index to 0; ready and both grants SHALL then read 0.
REQ-026 SHALL let reset in any state, including mid-INIT or mid-traffic, discard all list contents and restart INIT from index 0.
REQ-027 SHALL give no meaning to buffer contents before they are written; no explicit clear of the buffer is required.

Configuration
REQ-028 SHALL, with FREELIST_DUP_CHECK_EN defined, keep a NUM_PREG-bit in-list vector, set by init and release and cleared by grant.
REQ-029 SHALL, with FREELIST_DUP_CHECK_EN defined, drop a release of a tag already in the list, or of a tag below NUM_AREG that was never allocated, and set err.
REQ-030 SHALL, without FREELIST_DUP_CHECK_EN, have no in-list vector; duplicate releases are enqueued unchecked and only the REQ-016/REQ-023 errors exist.

Verification
REQ-031 SHALL check: reset, then 32 idle cycles -> ready rises on the 33rd cycle after reset release, free_count=32, err=0.
REQ-032 SHALL check: after ready, both lanes request for 1 cycle -> gnt0=gnt1=1, preg0=32, preg1=33, free_count=30 next cycle.
REQ-033 SHALL check: with free_count=1, both lanes request -> gnt0=1, preg0=<head tag>, gnt1=0; free_count=0 next cycle.
REQ-034 SHALL check: with free_count=0, rel_valid=1 with rel_preg=5 and alloc_req0=1 -> gnt0=0 that cycle; the next cycle gnt0=1 and preg0=5.
REQ-035 SHALL check: 100 cycles of random alloc/release with wrap past entry 63 -> grant order equals release order (FIFO) and free_count stays consistent.
REQ-036 SHALL check, with FREELIST_DUP_CHECK_EN defined: release tag 40 while it is free -> dropped, err=1, free_count unchanged; rst_n=0 mid-INIT -> INIT restarts and ready is delayed 32 cycles.
